bayer_demosaic_2x2: RTL

Converts the two raw Bayer line streams from the triple line buffer into 8-bit RGB pixels for the VGA path. Each output pixel comes from a 2×2 window: the current and previous column of the older and newer buffered lines. The block runs entirely in the VGA read clock domain, directly downstream of the line buffer's `taps0x`/`taps1x` outputs and upstream of the VGA output registers.

---
 rtl/demosaic_pkg.sv | 12 +
 rtl/bayer_window_2x2.sv | 69 ++++++
 rtl/bayer_demosaic_2x2.sv | 87 ++++++++
 3 files changed

// File: rtl/demosaic_pkg.sv
// demosaic_pkg: Bayer phase codes, default widths and colour-bar table for the 2x2 demosaic.
package demosaic_pkg;
  localparam logic [1:0] PH_RGGB = 2'd0;
  localparam logic [1:0] PH_GRBG = 2'd1;
  localparam logic [1:0] PH_GBRG = 2'd2;
  localparam logic [1:0] PH_BGGR = 2'd3;
  localparam int DEF_IN_W = 10;
  localparam int DEF_OUT_W = 8;
  localparam int COL_W = 11;
  // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
endpackage

// File: rtl/bayer_window_2x2.sv
// bayer_window_2x2: input register, line edge detect, cx/ry parity and the 2x2 raw window.
// Ports: clk, rst (sync, active-high), frame_start, req, t0/t1 taps in;
//        valid, prev0/cur0 (top row), prev1/cur1 (bottom row), cx, ry out;
//        col (valid-pixel column) only when DEMOSAIC_TESTPAT_EN is defined.
module bayer_window_2x2
  import demosaic_pkg::*;
#(
  parameter int IN_W = DEF_IN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            req,
  input  logic [IN_W-1:0] t0,
  input  logic [IN_W-1:0] t1,
`ifdef DEMOSAIC_TESTPAT_EN
  output logic [COL_W-1:0] col,
`endif
  output logic            valid,
  output logic [IN_W-1:0] prev0,
  output logic [IN_W-1:0] cur0,
  output logic [IN_W-1:0] prev1,
  output logic [IN_W-1:0] cur1,
  output logic            cx,
  output logic            ry
);
  logic blk, r_req, rise, fall;
  logic [IN_W-1:0] r_t0, r_t1;
  assign rise = r_req & ~valid;
  assign fall = ~r_req & valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      blk <= req;
      r_req <= 1'b0;
      r_t0 <= '0;
      r_t1 <= '0;
      valid <= 1'b0;
      prev0 <= '0;
      cur0 <= '0;
      prev1 <= '0;
      cur1 <= '0;
      cx <= 1'b0;
      ry <= 1'b0;
`ifdef DEMOSAIC_TESTPAT_EN
      col <= '0;
`endif
    end else begin
      // a line cut by reset stays suppressed until the request drops
      blk <= blk & req;
      r_req <= req & ~blk;
      r_t0 <= t0;
      r_t1 <= t1;
      valid <= r_req;
      ry <= frame_start ? 1'b0 : ry ^ fall;
      if (r_req) begin
        cur0 <= r_t0;
        cur1 <= r_t1;
        prev0 <= rise ? r_t0 : cur0;
        prev1 <= rise ? r_t1 : cur1;
        // cx is the parity of the window's left column; the first pixel is
        // replicated so its phase is irrelevant, and seeding 1 lands column 0 on the second
        cx <= rise | ~cx;
`ifdef DEMOSAIC_TESTPAT_EN
        col <= rise ? '0 : col + COL_W'(1);
`endif
      end
    end
  end
endmodule

// File: rtl/bayer_demosaic_2x2.sv
// bayer_demosaic_2x2: 2x2-window Bayer to RGB converter for the VGA path, 3-cycle latency.
// Ports: VGA_CLK, RST (sync, active-high), FRAME_START, READ_Request, taps0x (line N-2),
//        taps1x (line N-1) in; oRed/oGreen/oBlue, oDVAL out.
// DEMOSAIC_TESTPAT_EN adds input TESTPAT selecting 8 vertical colour bars.
module bayer_demosaic_2x2
  import demosaic_pkg::*;
#(
  parameter logic [1:0] BAYER_PHASE = PH_RGGB,
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             VGA_CLK,
  input  logic             RST,
  input  logic             FRAME_START,
  input  logic             READ_Request,
  input  logic [IN_W-1:0]  taps0x,
  input  logic [IN_W-1:0]  taps1x,
`ifdef DEMOSAIC_TESTPAT_EN
  input  logic             TESTPAT,
`endif
  output logic [OUT_W-1:0] oRed,
  output logic [OUT_W-1:0] oGreen,
  output logic [OUT_W-1:0] oBlue,
  output logic             oDVAL
);
  logic valid, cx, ry;
  logic [IN_W-1:0] p0, c0, p1, c1, r_raw, b_raw, ga, gb;
  logic [IN_W:0] g_sum;
  logic [1:0] ph;
  logic [OUT_W-1:0] r_dm, g_dm, b_dm, r_out, g_out, b_out;
`ifdef DEMOSAIC_TESTPAT_EN
  logic [COL_W-1:0] col;
  logic [2:0] bar;
`endif
  bayer_window_2x2 #(.IN_W(IN_W)) u_win (
    .clk(VGA_CLK),
    .rst(RST),
    .frame_start(FRAME_START),
    .req(READ_Request),
    .t0(taps0x),
    .t1(taps1x),
`ifdef DEMOSAIC_TESTPAT_EN
    .col(col),
`endif
    .valid(valid),
    .prev0(p0),
    .cur0(c0),
    .prev1(p1),
    .cur1(c1),
    .cx(cx),
    .ry(ry)
  );
  assign ph = BAYER_PHASE ^ {ry, cx};
  always_comb begin
    r_raw = ph == PH_RGGB ? p0 : ph == PH_GRBG ? c0 : ph == PH_GBRG ? p1 : c1;
    b_raw = ph == PH_RGGB ? c1 : ph == PH_GRBG ? p1 : ph == PH_GBRG ? c0 : p0;
    ga = ph[0] ^ ph[1] ? p0 : c0;
    gb = ph[0] ^ ph[1] ? c1 : p1;
    g_sum = {1'b0, ga} + {1'b0, gb};
  end
  assign r_dm = OUT_W'(r_raw >> (IN_W - OUT_W));
  assign b_dm = OUT_W'(b_raw >> (IN_W - OUT_W));
  assign g_dm = OUT_W'(g_sum >> (IN_W + 1 - OUT_W));
`ifdef DEMOSAIC_TESTPAT_EN
  assign bar = 3'(col >> 7);
  assign r_out = TESTPAT ? {OUT_W{BAR_RGB[bar][2]}} : r_dm;
  assign g_out = TESTPAT ? {OUT_W{BAR_RGB[bar][1]}} : g_dm;
  assign b_out = TESTPAT ? {OUT_W{BAR_RGB[bar][0]}} : b_dm;
`else
  assign r_out = r_dm;
  assign g_out = g_dm;
  assign b_out = b_dm;
`endif
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      oDVAL <= 1'b0;
      oRed <= '0;
      oGreen <= '0;
      oBlue <= '0;
    end else begin
      oDVAL <= valid;
      oRed <= valid ? r_out : '0;
      oGreen <= valid ? g_out : '0;
      oBlue <= valid ? b_out : '0;
    end
  end
endmodule
